// File: rtl/top_level.sv
// top_level: converts a signed 8.8 fixed-point word in memory to an IEEE half-precision float
module top_level (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ack
);
  typedef enum logic [2:0] {IDLE, LOAD, ABS, NORM, PACK, WRITE, DONE} state_t;
  state_t state, next;
  logic [15:0] x, mag, f, mem_x;
  logic [3:0] cnt;
  logic s;
  logic [7:0] pc_val;
  logic [8:0] instr;
  logic unused_dbg;
  data_mem dm (
    .clk(clk),
    .we(state == WRITE && !reset),
    .wdata(f),
    .x(mem_x)
  );
  program_counter pc (
    .clk(clk),
    .reset(reset),
    .busy(state != IDLE && state != DONE),
    .current_pc_out(pc_val)
  );
  instr_decode im (
    .state(state),
    .cnt(cnt),
    .instruction(instr)
  );
  control_done cd (
    .done_in(state == DONE),
    .done(ack)
  );
  assign unused_dbg = ^{pc_val, instr};
  // state register; reset wins over start
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  // next-state: a zero input skips normalisation, DONE is sticky until reset
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? LOAD : IDLE;
      LOAD:    next = ABS;
      ABS:     next = (x == 16'd0) ? PACK : NORM;
      NORM:    next = mag[15] ? PACK : NORM;
      PACK:    next = WRITE;
      WRITE:   next = DONE;
      default: next = state;
    endcase
  end
  // datapath: magnitude is shifted until its MSB is set; the shift count gives the exponent
  always_ff @(posedge clk)
    if (reset) begin
      x   <= '0;
      mag <= '0;
      s   <= 1'b0;
      cnt <= '0;
      f   <= '0;
    end else
      case (state)
        LOAD: x <= mem_x;
        ABS: begin
          s   <= x[15];
          mag <= x[15] ? ~x + 16'd1 : x;
          cnt <= '0;
        end
        NORM: if (!mag[15]) begin
          mag <= mag << 1;
          cnt <= cnt + 4'd1;
        end
        PACK: f <= (mag == 16'd0) ? 16'd0 : {s, 5'd22 - {1'b0, cnt}, mag[14:5]};
        default: ;
      endcase
endmodule

// data_mem: 256 x 8 data memory; input word at bytes 0..1, result written to bytes 2..3
module data_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] x
);
  logic [7:0] mem_core [0:255];
  // both result bytes land on the same edge; contents are never cleared by reset
  always @(posedge clk)
    if (we) begin
      mem_core[2] <= wdata[7:0];
      mem_core[3] <= wdata[15:8];
    end
  assign x = {mem_core[1], mem_core[0]};
endmodule

// program_counter: counts steps taken by the current conversion
module program_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy,
  output logic [7:0] current_pc_out
);
  // advances only while a conversion is in flight
  always_ff @(posedge clk)
    current_pc_out <= reset ? 8'd0 : busy ? current_pc_out + 8'd1 : current_pc_out;
endmodule

// instr_decode: exposes the current step code (shift count and state)
module instr_decode (
  input  logic [2:0] state,
  input  logic [3:0] cnt,
  output logic [8:0] instruction
);
  assign instruction = {2'b00, cnt, state};
endmodule

// control_done: completion flag
module control_done (
  input  logic done_in,
  output logic done
);
  assign done = done_in;
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: vector table, scoreboard queue and corner sequences for the fixed-to-half converter
module tb_top_level;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ack;
  int n_chk = 0, n_fail = 0;
  logic [15:0] sb[$];
  typedef struct {
    logic [15:0] x;
    logic [15:0] f;
  } vec_t;
  vec_t vecs[9];

  top_level dut (.clk(clk), .reset(reset), .start(start), .ack(ack));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x);
    logic [15:0] m;
    logic [31:0] wide;
    logic [9:0] man;
    int p;
    if (x == 16'd0) return 16'd0;
    m = x[15] ? (~x) + 16'd1 : x;
    p = 0;
    for (int i = 0; i < 16; i++) if (m[i]) p = i;
    wide = {16'd0, m};
    man = (p >= 10) ? 10'(wide >> (p - 10)) : 10'(wide << (10 - p));
    return {x[15], 5'(p + 7), man};
  endfunction

  task automatic conv(input logic [15:0] x, input int hold, input string name);
    int n;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk({name, " ack_after_reset"}, {31'd0, ack}, 32'd0);
    dut.dm.mem_core[0] = x[7:0];
    dut.dm.mem_core[1] = x[15:8];
    dut.dm.mem_core[2] = 8'h5A;
    dut.dm.mem_core[3] = 8'hA5;
    sb.push_back(model(x));
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n >= hold) start = 1'b0;
    end while (!ack && n < 24);
    start = 1'b0;
    chk({name, " ack_within_24"}, {31'd0, ack}, 32'd1);
    chk({name, " result"}, {16'd0, dut.dm.mem_core[3], dut.dm.mem_core[2]}, {16'd0, sb.pop_front()});
    chk({name, " input_kept"}, {16'd0, dut.dm.mem_core[1], dut.dm.mem_core[0]}, {16'd0, x});
  endtask

  initial begin
    int rises;
    logic prev;
    logic [15:0] rx;
    vecs[0] = '{16'h0000, 16'h0000};
    vecs[1] = '{16'h0001, 16'h1C00};
    vecs[2] = '{16'h0030, 16'h3200};
    vecs[3] = '{16'h1FFF, 16'h4FFF};
    vecs[4] = '{16'h7FFF, 16'h57FF};
    vecs[5] = '{16'hFFFF, 16'h9C00};
    vecs[6] = '{16'hFFF4, 16'hAA00};
    vecs[7] = '{16'h8000, 16'hD800};
    vecs[8] = '{16'h8001, 16'hD7FF};

    repeat (3) @(negedge clk);
    chk("reset ack", {31'd0, ack}, 32'd0);
    chk("reset pc", {24'd0, dut.pc.current_pc_out}, 32'd0);
    chk("reset cd_done", {31'd0, dut.cd.done}, 32'd0);

    foreach (vecs[i]) begin
      conv(vecs[i].x, 1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table", i), {16'd0, dut.dm.mem_core[3], dut.dm.mem_core[2]}, {16'd0, vecs[i].f});
      chk($sformatf("vec%0d cd_done", i), {31'd0, dut.cd.done}, 32'd1);
    end

    conv(16'h0030, 2, "hold2");
    @(negedge clk);
    start = 1'b1;
    rises = 0;
    prev = ack;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (ack && !prev) rises++;
      prev = ack;
    end
    chk("hold2 no_extra_rise", rises, 0);
    chk("hold2 ack_sticky", {31'd0, ack}, 32'd1);
    chk("hold2 result_kept", {16'd0, dut.dm.mem_core[3], dut.dm.mem_core[2]}, 32'h3200);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dut.dm.mem_core[0] = 8'h01;
    dut.dm.mem_core[1] = 8'h00;
    dut.dm.mem_core[2] = 8'h11;
    dut.dm.mem_core[3] = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort pc", {24'd0, dut.pc.current_pc_out}, 32'd0);
    repeat (30) @(negedge clk);
    chk("abort ack", {31'd0, ack}, 32'd0);
    chk("abort no_write", {16'd0, dut.dm.mem_core[3], dut.dm.mem_core[2]}, 32'h2211);
    chk("abort input_kept", {16'd0, dut.dm.mem_core[1], dut.dm.mem_core[0]}, 32'h0001);

    for (int i = 0; i < 110; i++) begin
      rx = (i == 50) ? 16'h8000 : 16'($urandom_range(0, 32'h7FFF));
      conv(rx, 1, $sformatf("rand%0d_%h", i, rx));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
